// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, channel mode encoding and the channel mode
// decode helper for the PWM output peripheral.
// Optional build macro used by the consumers of this package:
//   PWM_SHADOW_DUTY_EN - the duty cycle is latched once per PWM period.
package pwm_pkg;

  localparam int NUM_CH = 16;
  localparam int CNT_W  = 8;
  localparam int PRE_W  = 16;

  localparam logic [CNT_W-1:0] DUTY_FULL = 8'hFF;
  localparam logic [CNT_W-1:0] CNT_MAX   = 8'hFF;

  typedef enum logic [1:0] {
    MODE_OFF         = 2'd0,
    MODE_STATIC_HIGH = 2'd1,
    MODE_PWM         = 2'd2
  } ch_mode_e;

  // Output enable has priority: a disabled channel is low whatever its mode bit.
  function automatic ch_mode_e ch_mode(input logic en_out, input logic en_pwm);
    ch_mode_e m;
    m = MODE_OFF;
    if (en_out) begin
      m = en_pwm ? MODE_PWM : MODE_STATIC_HIGH;
    end
    return m;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// pwm_prescaler: free-running divider producing a one-cycle tick every
// CLK_DIV system clocks (every clock when CLK_DIV = 1).
// Parameters: CLK_DIV (1..65535) clocks per tick.
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   tick  out high on the last cycle of each CLK_DIV-cycle interval
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 output pins from the SPI configuration registers.
// Each pin is off, static high, or follows one shared 8-bit PWM waveform.
// Build macro: PWM_SHADOW_DUTY_EN - when defined, the duty cycle is held in a
// shadow register that only reloads at the 255->0 counter wrap, so a period
// is never truncated or stretched by a mid-period duty write.
// Parameters: CLK_DIV (1..65535) system clocks per PWM counter step.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   en_reg_out_15_8/7_0 per-channel output enable
//   en_reg_pwm_15_8/7_0 per-channel PWM mode select
//   pwm_duty_cycle     duty; 0xFF means always high
//   out                registered pin outputs
//   period_start       one-cycle pulse after each counter wrap
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 13
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            en_reg_out_7_0,
  input  logic [7:0]            en_reg_out_15_8,
  input  logic [7:0]            en_reg_pwm_7_0,
  input  logic [7:0]            en_reg_pwm_15_8,
  input  logic [7:0]            pwm_duty_cycle,
  output logic [NUM_CH-1:0]     out,
  output logic                  period_start
);

  logic             tick;
  logic             wrap;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] duty_eff;
  logic             pwm_sig;
  logic [NUM_CH-1:0] en_out;
  logic [NUM_CH-1:0] en_pwm;
  logic [NUM_CH-1:0] out_next;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // The tick that moves cnt from 255 to 0.
  assign wrap = tick && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef PWM_SHADOW_DUTY_EN
  logic [CNT_W-1:0] duty_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
    end else if (wrap) begin
      duty_shadow <= pwm_duty_cycle;
    end
  end

  assign duty_eff = duty_shadow;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  // 0xFF is special-cased so that "full" really is 256/256 high.
  assign pwm_sig = (duty_eff == DUTY_FULL) || (cnt < duty_eff);

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_mode_e mode;
    assign mode        = ch_mode(en_out[g], en_pwm[g]);
    assign out_next[g] = (mode == MODE_PWM) ? pwm_sig : (mode == MODE_STATIC_HIGH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      out          <= out_next;
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with CLK_DIV = 4.
// Every driven clock edge n (counted from reset release) gets an expected
// {period_start, out} derived from closed-form timing: the counter value seen
// by edge n is ((n-1)/CLK_DIV) mod 256, and a wrap lands on every edge that
// is a multiple of 256*CLK_DIV. A monitor pops and compares after each edge.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 256 * CLK_DIV;
`ifdef PWM_SHADOW_DUTY_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  // scoreboard
  logic [16:0] exp_q[$];
  int          tag_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_edges = 0;
  logic [7:0]  sh_model = 8'h00;
  int          hi_cnt = 0;
  int          ps_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: one expected entry per driven edge
  logic [16:0] mon_e;
  int          mon_t;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      check($sformatf("edge%0d {ps,out}", mon_t), {15'd0, period_start, out}, {15'd0, mon_e});
    end
  end

  // driver: push expectation for the next edge, then let it happen
  task automatic step();
    int          n;
    logic [7:0]  cp;
    logic [7:0]  de;
    logic        pwm;
    logic [15:0] eo, ep, o;
    logic        ps;
    n   = n_edges + 1;
    cp  = 8'(((n - 1) / CLK_DIV) % 256);
    de  = SHADOW ? sh_model : pwm_duty_cycle;
    pwm = (de == 8'hFF) ? 1'b1 : (cp < de);
    eo  = {en_reg_out_15_8, en_reg_out_7_0};
    ep  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    o   = eo & (~ep | {16{pwm}});
    ps  = ((n % PERIOD) == 0);
    if (SHADOW && ps) sh_model = pwm_duty_cycle;
    exp_q.push_back({ps, o});
    tag_q.push_back(n);
    n_edges = n;
    @(negedge clk);
    if (out[0]) hi_cnt++;
    if (period_start) ps_cnt++;
  endtask

  task automatic run_edges(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic set_inputs(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    pwm_duty_cycle = d;
  endtask

  // called at a negedge; leaves the DUT just released, before its first edge
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check({name, " out in reset"}, out, 16'h0000);
    check({name, " ps in reset"}, period_start, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check({name, " out held in reset"}, out, 16'h0000);
    rst_n    = 1'b1;
    n_edges  = 0;
    sh_model = 8'h00;
    check({name, " out after release"}, out, 16'h0000);
    check({name, " ps after release"}, period_start, 1'b0);
  endtask

  initial begin
    int first_ps;
    set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
    @(negedge clk);

    // reset with everything enabled
    do_reset("reset");
    run_edges(4);

    // static high on low byte, then a mode mix with one-cycle latency
    @(negedge clk);
    set_inputs(16'h00FF, 16'h0000, 8'h80);
    do_reset("static");
    run_edges(8);
    check("static out", out, 16'h00FF);
    set_inputs(16'hFF0F, 16'h0F00, 8'h80);
    run_edges(40);

    // 50% duty
    set_inputs(16'hFFFF, 16'hFFFF, 8'h80);
    do_reset("pwm50");
    run_edges(PERIOD);
    hi_cnt = 0; ps_cnt = 0;
    run_edges(PERIOD);
    check("pwm50 high clocks", hi_cnt, 512);
    check("pwm50 period_start count", ps_cnt, 1);

    // duty 0x00: never high over two periods
    set_inputs(16'hFFFF, 16'hFFFF, 8'h00);
    do_reset("duty00");
    hi_cnt = 0; ps_cnt = 0;
    run_edges(2 * PERIOD);
    check("duty00 high clocks", hi_cnt, 0);
    check("duty00 period_start count", ps_cnt, 2);

    // duty 0xFF: always high
    set_inputs(16'hFFFF, 16'hFFFF, 8'hFF);
    do_reset("dutyFF");
    run_edges(PERIOD);
    hi_cnt = 0;
    run_edges(PERIOD);
    check("dutyFF high clocks", hi_cnt, PERIOD);

    // duty 0x01: one tick high
    set_inputs(16'hFFFF, 16'hFFFF, 8'h01);
    do_reset("duty01");
    run_edges(PERIOD);
    hi_cnt = 0;
    run_edges(PERIOD);
    check("duty01 high clocks", hi_cnt, CLK_DIV);

    // duty 0x40 -> 0xC0 written at cnt = 0x80 of the second period
    set_inputs(16'hFFFF, 16'hFFFF, 8'h40);
    do_reset("shadow");
    run_edges(PERIOD);
    hi_cnt = 0;
    run_edges(PERIOD / 2);
    pwm_duty_cycle = 8'hC0;
    run_edges(1);
    check("duty write next update", out, SHADOW ? 16'h0000 : 16'hFFFF);
    run_edges(PERIOD / 2 - 1);
    check("duty write period high", hi_cnt, SHADOW ? 256 : 512);
    hi_cnt = 0;
    run_edges(PERIOD);
    check("new duty period high", hi_cnt, 768);

    // reset at cnt = 0x9A in the second period
    set_inputs(16'hFFFF, 16'hFFFF, 8'hFF);
    do_reset("midreset");
    run_edges(PERIOD + 154 * CLK_DIV);
    check("midreset out before", out, 16'hFFFF);
    rst_n = 1'b0;
    #1;
    check("midreset out async", out, 16'h0000);
    check("midreset ps async", period_start, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    n_edges  = 0;
    sh_model = 8'h00;
    first_ps = -1;
    ps_cnt   = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      step();
      if (ps_cnt != 0) begin
        first_ps = n_edges;
        break;
      end
    end
    check("midreset first period_start", first_ps, PERIOD);

    @(negedge clk);
    check("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
